write_cmd_arbiter: RTL
======================

WRITE_CMD_ARBITER -- requirements
Module: write_cmd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 40, write address width.
REQ-002 SHALL have parameter DATA_W, default 32, write data width.
REQ-003 SHALL have parameter DEPTH, default 4, per-requester FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port aresetb  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports in0_addr/in1_addr  input  ADDR_W  requester write address.
REQ-007 SHALL have ports in0_data/in1_data  input  DATA_W  requester write data.
REQ-008 SHALL have ports in0_valid/in1_valid  input  1  single-cycle write pulse, no backpressure.
REQ-009 SHALL have port out_addr  output  ADDR_W  granted write address.
REQ-010 SHALL have port out_data  output  DATA_W  granted write data.
REQ-011 SHALL have port out_valid  output  1  granted write pending.
REQ-012 SHALL have port out_ready  input  1  target accepts out_* when high with out_valid.
REQ-013 SHALL have port out_src  output  1  requester index of current out_* (0 or 1).
REQ-014 SHALL have port ovf_clear  input  1  clears overflow flags.
REQ-015 SHALL have port overflow  output  2  sticky per-requester drop flag, bit N = requester N.
REQ-016 SHALL have port idle  output  1  high when both FIFOs empty, out_valid low, state IDLE.

Function
REQ-017 SHALL buffer each requester in its own DEPTH-entry FIFO of {addr,data}, order preserved.
REQ-018 SHALL push inN on rising edge where inN_valid=1 and (countN<DEPTH or popN same edge).
REQ-019 SHALL drop inN_valid when FIFO full and no same-edge pop; set overflow[N] on that edge.
REQ-020 SHALL clear overflow on edge with ovf_clear=1, unless new drop same edge (set wins).
REQ-021 SHALL implement FSM states IDLE and HOLD.
REQ-022 IDLE: if any FIFO non-empty, SHALL select one, load head into out_addr/out_data/out_src, pop it, set out_valid=1, go HOLD.
REQ-023 Selection: single non-empty FIFO wins; both non-empty -> requester != last_grant.
REQ-024 SHALL update last_grant to selected index on each selection; last_grant resets to 1 (requester 0 wins first tie).
REQ-025 HOLD: out_addr/out_data/out_src/out_valid SHALL remain stable while out_ready=0.
REQ-026 HOLD with out_ready=1: SHALL clear out_valid, go IDLE; one idle bubble before next grant.
REQ-027 Latency: inN_valid at edge E0, FIFOs empty, IDLE -> out_valid high after edge E1.
REQ-028 Max throughput one write per 2 cycles; FIFO count width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-029 SHALL accept simultaneous in0_valid and in1_valid, pushing both independently.
REQ-030 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-031 aresetb=0 SHALL immediately force: state IDLE, out_valid=0, out_src=0, overflow=0, FIFOs empty, last_grant=1, out_addr=0, out_data=0.
REQ-032 Reset mid-HOLD SHALL discard pending output and all buffered entries; no write emitted after release.
REQ-033 First push possible on first rising edge with aresetb=1.

Verification
REQ-034 Single write: in0 pulse addr=0x10,data=0xA5 -> out_valid high after next edge, out_addr=0x10, out_data=0xA5, out_src=0; out_ready=1 -> idle=1 following cycle.
REQ-035 Tie: in0 (0x100) and in1 (0x200) same edge, out_ready=1 -> outputs 0x100 src0, then 0x200 src1; 2 more each alternate 0,1.
REQ-036 Backpressure: out_ready=0 for 10 cycles -> out_* stable; then out_ready=1 -> exactly one transfer.
REQ-037 Overflow: out_ready=0, 6 in1 pulses, DEPTH=4 -> 1 in HOLD, 4 buffered, 6th dropped, overflow=2'b10; ovf_clear -> 2'b00; 5 writes emitted in order.
REQ-038 Full+pop: FIFO0 full, pop and in0 push same edge -> push accepted, overflow[0]=0.
REQ-039 Async reset mid-HOLD: aresetb low between edges -> out_valid=0, idle=1 without clock edge; no later emission of old entries.

Source files
------------

// File: rtl/write_cmd_arbiter.sv
// write_cmd_arbiter: two-requester write command arbiter.
// Each requester has its own FIFO of {addr,data}. A two-state FSM picks a
// non-empty FIFO, pops its head into the output registers and holds it until
// the target accepts it. Ties alternate between requesters.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no write presented; pick a non-empty FIFO and load its head
// HOLD    | out_* valid and stable; wait for out_ready, then return to IDLE
module write_cmd_arbiter #(
  parameter int ADDR_W = 40,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              aresetb,
  input  logic [ADDR_W-1:0] in0_addr,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_valid,
  input  logic [ADDR_W-1:0] in1_addr,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_src,
  input  logic              ovf_clear,
  output logic [1:0]        overflow,
  output logic              idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [EW-1:0] w_in_ent [2];
  logic [1:0]    w_in_valid;
  logic [EW-1:0] w_head [2];
  logic [1:0]    w_nonempty;
  logic [1:0]    w_pop;
  logic [1:0]    w_push;
  logic [1:0]    w_drop;

  logic          w_sel_fire;
  logic          w_sel_src;
  logic [EW-1:0] w_sel_head;

  logic              r_last_grant;
  logic              r_out_valid;
  logic              r_out_src;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_ovf;

  assign w_in_ent[0] = {in0_addr, in0_data};
  assign w_in_ent[1] = {in1_addr, in1_data};
  assign w_in_valid  = {in1_valid, in0_valid};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;

    assign w_nonempty[g] = (r_cnt != '0);
    assign w_head[g]     = r_mem[r_rptr];
    // A full FIFO still accepts a push when its head leaves on the same edge.
    assign w_push[g]     = w_in_valid[g] && ((r_cnt != CNT_FULL) || w_pop[g]);
    assign w_drop[g]     = w_in_valid[g] && !w_push[g];

    // Entry storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
      if (w_push[g]) r_mem[r_wptr] <= w_in_ent[g];
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge aresetb) begin
      if (!aresetb) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push[g]) r_wptr <= r_wptr + 1'b1;
        if (w_pop[g])  r_rptr <= r_rptr + 1'b1;
        case ({w_push[g], w_pop[g]})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    // Sticky drop flag; a drop on the clearing edge keeps the flag set.
    always_ff @(posedge clk or negedge aresetb) begin
      if (!aresetb) begin
        r_ovf[g] <= 1'b0;
      end else if (w_drop[g]) begin
        r_ovf[g] <= 1'b1;
      end else if (ovf_clear) begin
        r_ovf[g] <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge aresetb) begin
    if (!aresetb) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_sel_fire) w_state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: grant selection and FIFO pop, only while IDLE.
  always_comb begin
    w_sel_fire = 1'b0;
    w_sel_src  = 1'b0;
    w_pop      = 2'b00;
    if (r_state == ST_IDLE) begin
      case (w_nonempty)
        2'b01: begin
          w_sel_fire = 1'b1;
          w_sel_src  = 1'b0;
        end
        2'b10: begin
          w_sel_fire = 1'b1;
          w_sel_src  = 1'b1;
        end
        2'b11: begin
          w_sel_fire = 1'b1;
          w_sel_src  = ~r_last_grant;
        end
        default: begin
          w_sel_fire = 1'b0;
          w_sel_src  = 1'b0;
        end
      endcase
      if (w_sel_fire) w_pop[w_sel_src] = 1'b1;
    end
  end

  assign w_sel_head = w_head[w_sel_src];

  // Output registers: load on grant, drop valid on acceptance.
  always_ff @(posedge clk or negedge aresetb) begin
    if (!aresetb) begin
      r_out_valid  <= 1'b0;
      r_out_src    <= 1'b0;
      r_out_addr   <= '0;
      r_out_data   <= '0;
      r_last_grant <= 1'b1;
    end else if (w_sel_fire) begin
      r_out_valid  <= 1'b1;
      r_out_src    <= w_sel_src;
      r_out_addr   <= w_sel_head[EW-1:DATA_W];
      r_out_data   <= w_sel_head[DATA_W-1:0];
      r_last_grant <= w_sel_src;
    end else if ((r_state == ST_HOLD) && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign overflow  = r_ovf;
  assign idle      = !w_nonempty[0] && !w_nonempty[1] && !r_out_valid
                     && (r_state == ST_IDLE);

endmodule
